dem_dwa_scrambler: RTL and testbench

//   Downstream consumer of pn_sequence_generator in the DEM-DAC path. Converts a

---
 rtl/dem_pkg.sv | 13 +
 rtl/dem_rotator.sv | 27 ++
 rtl/dem_dwa_scrambler.sv | 87 ++++++++
 tb/tb_dem_dwa_scrambler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dem_pkg.sv
// Shared types and defaults for the DEM-DAC blocks.
package dem_pkg;

    typedef enum logic [1:0] {
        THERM = 2'b00,
        DWA   = 2'b01,
        RDWA  = 2'b10,
        RSVD  = 2'b11
    } dem_mode_t;

    localparam int unsigned DEM_N_ELEM_DEFAULT = 8;

endpackage

// File: rtl/dem_rotator.sv
// Thermometer-encodes an element count and rotates it left by the pointer.
module dem_rotator
    import dem_pkg::*;
#(
    parameter int unsigned N_ELEM = DEM_N_ELEM_DEFAULT,
    parameter int unsigned CODE_W = $clog2(N_ELEM) + 1,
    localparam int unsigned PTR_W = $clog2(N_ELEM)
) (
    input  logic [CODE_W-1:0] c,
    input  logic [PTR_W-1:0]  ptr,
    output logic [N_ELEM-1:0] sel
);

    logic [N_ELEM-1:0] therm;
    logic [PTR_W:0]    rsh;

    always_comb begin
        therm = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            therm[i] = (CODE_W'(i) < c);
        end
        // ptr = 0 gives a right shift of N_ELEM, which contributes nothing.
        rsh = (PTR_W + 1)'(N_ELEM) - {1'b0, ptr};
        sel = (therm << ptr) | (therm >> rsh);
    end

endmodule

// File: rtl/dem_dwa_scrambler.sv
// Binary code to unit-element select with THERM / DWA / PN-randomized DWA rotation.
module dem_dwa_scrambler
    import dem_pkg::*;
#(
    parameter int unsigned N_ELEM = DEM_N_ELEM_DEFAULT,
    parameter int unsigned CODE_W = $clog2(N_ELEM) + 1,
    localparam int unsigned PTR_W = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              pn_seq,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_ELEM-1:0] elem_sel,
    output logic              sat_err,
    output logic [PTR_W-1:0]  ptr_dbg
);

    dem_mode_t         mode_e;
    logic              accept;
    logic              over;
    logic [CODE_W-1:0] c;
    logic [PTR_W-1:0]  rot_ptr;
    logic [PTR_W+1:0]  sum;
    logic [PTR_W-1:0]  ptr_d;
    logic [N_ELEM-1:0] rot_sel;

    logic              out_valid_q;
    logic [N_ELEM-1:0] elem_sel_q;
    logic              sat_err_q;
    logic [PTR_W-1:0]  ptr_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        mode_e  = dem_mode_t'(mode);
        over    = in_code > CODE_W'(N_ELEM);
        c       = over ? CODE_W'(N_ELEM) : in_code;
        rot_ptr = (mode_e == THERM) ? '0 : ptr_q;
        sum     = (PTR_W + 2)'(ptr_q) + (PTR_W + 2)'(c);
        // RSVD behaves as plain DWA.
        case (mode_e)
            THERM:   ptr_d = '0;
            RDWA:    ptr_d = PTR_W'(sum + (PTR_W + 2)'(pn_seq));
            default: ptr_d = PTR_W'(sum);
        endcase
    end

    dem_rotator #(
        .N_ELEM (N_ELEM),
        .CODE_W (CODE_W)
    ) u_rotator (
        .c   (c),
        .ptr (rot_ptr),
        .sel (rot_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            elem_sel_q  <= '0;
            sat_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            sat_err_q <= 1'b0;
            if (accept) begin
                out_valid_q <= 1'b1;
                elem_sel_q  <= rot_sel;
                sat_err_q   <= over;
                ptr_q       <= ptr_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign elem_sel  = elem_sel_q;
    assign sat_err   = sat_err_q;
    assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_dem_dwa_scrambler.sv
// Scoreboard bench for dem_dwa_scrambler: directed cases then randomized traffic.
module tb_dem_dwa_scrambler;

    localparam int N = 8;

    typedef struct {
        logic [7:0] elem;
        int         ptr;
        bit         sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       pn_seq;
    logic       in_valid;
    logic [3:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] elem_sel;
    logic       sat_err;
    logic [2:0] ptr_dbg;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    int   model_ptr = 0;
    bit   fresh = 1'b1;
    logic [7:0] last_elem = '0;
    logic [2:0] last_ptr = '0;

    always #5 clk = ~clk;

    dem_dwa_scrambler #(.N_ELEM(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .pn_seq    (pn_seq),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .elem_sel  (elem_sel),
        .sat_err   (sat_err),
        .ptr_dbg   (ptr_dbg)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Element i is on when it lies within c positions after the pointer, wrapping.
    function automatic logic [7:0] model_sel(input int p, input int c);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            if (((i - p + N) % N) < c) s[i] = 1'b1;
        end
        return s;
    endfunction

    task automatic cycle(input bit v, input int code, input int m, input bit pn, input bit rdy);
        int   c;
        exp_t e;
        @(posedge clk);
        #2;
        in_valid  = v;
        in_code   = 4'(code);
        mode      = 2'(m);
        pn_seq    = pn;
        out_ready = rdy;
        @(negedge clk);
        if (in_valid && in_ready) begin
            c = (code > N) ? N : code;
            if (m == 0) begin
                e.elem    = model_sel(0, c);
                model_ptr = 0;
            end else begin
                e.elem = model_sel(model_ptr, c);
                if (m == 2) model_ptr = (model_ptr + c + (pn ? 1 : 0)) % N;
                else        model_ptr = (model_ptr + c) % N;
            end
            e.ptr = model_ptr;
            e.sat = (code > N);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            fresh = 1'b1;
        end else begin
            if (out_valid && fresh) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("elem_sel", elem_sel, e.elem);
                    chk("ptr_dbg", ptr_dbg, e.ptr);
                    chk("sat_err", sat_err, e.sat);
                end
                last_elem = elem_sel;
                last_ptr  = ptr_dbg;
            end else begin
                chk("sat_err_idle", sat_err, 0);
                if (out_valid) begin
                    chk("elem_sel_hold", elem_sel, last_elem);
                    chk("ptr_hold", ptr_dbg, last_ptr);
                end
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            fresh = !out_valid || out_ready;
        end
    end

    initial begin
        reset = 1'b0; mode = 2'd1; pn_seq = 1'b0;
        in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_elem_sel", elem_sel, 0);
        chk("rst_ptr", ptr_dbg, 0);
        chk("rst_sat", sat_err, 0);
        #1 reset = 1'b1;

        // DWA 3,3,3 then THERM 5,5
        repeat (3) cycle(1, 3, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        chk("dwa_ptr_after_3x3", ptr_dbg, 1);
        repeat (2) cycle(1, 5, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("therm_ptr", ptr_dbg, 0);

        // RDWA with a PN skip, then without
        cycle(1, 2, 2, 1, 1);
        cycle(1, 2, 2, 0, 1);
        cycle(0, 0, 2, 0, 1);
        chk("rdwa_ptr", ptr_dbg, 5);

        // saturation and code boundaries
        cycle(1, 12, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(1, 0, 1, 1, 1);
        cycle(1, 0, 2, 1, 1);
        cycle(1, 8, 2, 1, 1);
        cycle(1, 8, 1, 0, 1);
        cycle(1, 7, 3, 0, 1);

        // downstream stall for 4 cycles, then release
        cycle(1, 1, 1, 0, 1);
        repeat (4) cycle(1, 4, 1, 0, 0);
        cycle(1, 4, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);

        // reset mid-stream
        cycle(1, 3, 1, 0, 1);
        cycle(1, 6, 1, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_elem_sel", elem_sel, 0);
        chk("midrst_ptr", ptr_dbg, 0);
        q.delete();
        model_ptr = 0;
        @(posedge clk);
        #2 reset = 1'b1;

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 7));
        end

        repeat (4) cycle(0, 0, 1, 0, 1);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
